ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage. Replaces the single-cycle combinational multiply and bare HI/LO pair.
- Owns the HI/LO registers and runs signed/unsigned MULT, DIV, MADD and MSUB over a parametrised data width.
- Holds the pipeline with a stall request until the result is committed to HI/LO.
- Sits beside the EX ALU and is fed the same operands. MFHI/MFLO read its hi_o/lo_o.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits
MUL_LAT, 3, cycles from accepted start to MULT/MADD/MSUB commit; legal range 1..8

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  request to launch op; sampled only in IDLE
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
src1  in  DATA_W  multiplicand / dividend
src2  in  DATA_W  multiplier / divisor
cancel  in  1  pipeline flush; aborts the running op
hi_we  in  1  MTHI write enable
hi_wdata  in  DATA_W  MTHI data
lo_we  in  1  MTLO write enable
lo_wdata  in  DATA_W  MTLO data
hi_o  out  DATA_W  registered HI
lo_o  out  DATA_W  registered LO
busy  out  1  op in flight (registered)
done  out  1  one-cycle pulse on commit (registered)
div_zero  out  1  registered with done; divisor was zero
stall_req  out  1  combinational hold request to the pipeline

Behaviour:
- Reset (rst=0, async): state=IDLE; hi_o, lo_o, busy, done, div_zero, counters and operand latches = 0.
- States: IDLE, MUL, DIV.
  - IDLE: if start & ~cancel, latch op/src1/src2 and go to MUL (op 0,1,4..7) or DIV (op 2,3); busy=1 next edge. If start & cancel, nothing is launched.
  - MUL: count MUL_LAT-1 further cycles. On the MUL_LAT-th edge after acceptance, commit and return to IDLE.
  - DIV: 1 setup cycle (absolute values, zero check), DATA_W restoring iterations, 1 sign fix-up. Commit on edge DATA_W+2 after acceptance and return to IDLE.
- Commit edge: HI/LO updated, done=1 and busy=0 together. done drops the next cycle unless another commit occurs.
- start in the done cycle is accepted (back-to-back ops allowed). start while busy is ignored and not queued.
- Arithmetic:
  - MULT/MADD/MSUB are signed 2*DATA_W products; the U variants are unsigned.
  - MULT(U): {HI,LO}=product.
  - MADD(U): {HI,LO}={HI,LO}+product, modulo 2^(2*DATA_W).
  - MSUB(U): {HI,LO}={HI,LO}-product, modulo 2^(2*DATA_W).
  - Accumulate ops use the HI/LO value present at the commit edge.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU is unsigned.
  - Divisor 0: LO=all ones, HI=src1, div_zero=1 for the done cycle; no other side effect. div_zero is 0 on every other done.
  - Signed MIN / -1: LO=MIN, HI=0, div_zero=0.
- MTHI/MTLO:
  - hi_we/lo_we write on the edge only when state=IDLE; ignored while busy.
  - Same cycle as an accepted start: the write takes effect, and a later MADD/MSUB accumulates onto it.
- cancel while busy: next edge goes to IDLE, busy=0, no done, HI/LO unchanged. cancel in IDLE only blocks start.
- stall_req = (busy & ~commit_this_cycle & ~cancel) | (state==IDLE & start & ~cancel). It is 0 in the done cycle so the pipeline advances as the result appears.
- hi_o/lo_o change only at commit, MTHI/MTLO or reset.

Test Plan:
- DATA_W=32, MUL_LAT=3. MULT 0xFFFFFFFE×3 accepted at edge T0 -> done at T0+3; HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_req high for 3 cycles including the start cycle.
- MULTU 0xFFFFFFFE×3 -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9(-7)/2 -> done at T0+34; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064, div_zero=1 in the done cycle only.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU 1×1 -> HI=1, LO=0.
- With HI/LO=0, MSUB 1×1 -> HI=LO=0xFFFFFFFF.
- DIV started, cancel at the 5th busy cycle -> busy=0 next cycle, no done, HI/LO unchanged.
- start pulsed mid-op -> ignored.
- Async reset mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit that owns HI/LO. Multiplies commit after
// MUL_LAT cycles; divides use a restoring divider and commit DATA_W+2 cycles after start.
module ex_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              cancel,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              stall_req,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 2) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_ITER = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [DATA_W-1:0]   r_quo, r_rem, r_dvs;
  logic                r_busy, r_done, r_div_zero;

  logic                w_accept, w_commit;
  logic                w_signed, w_a_neg, w_b_neg, w_dz;
  logic [DATA_W-1:0]   w_a_abs, w_b_abs, w_q_fix, w_r_fix;
  logic [2*DATA_W-1:0] w_ea, w_eb, w_prod, w_acc, w_mul_res;
  logic [DATA_W:0]     w_sh;

  // Handshake: start is a request sampled only in IDLE; the pipeline holds
  // while stall_req is high and advances in the cycle done is asserted.

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && !cancel) w_next = (op[2:1] == 2'b01) ? S_DIV : S_MUL;
      S_MUL:  if (cancel || r_cnt == MUL_LAST) w_next = S_IDLE;
      S_DIV:  if (cancel || r_cnt == DIV_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = (r_state == S_IDLE) && start && !cancel;
    w_commit  = !cancel && (((r_state == S_MUL) && (r_cnt == MUL_LAST)) ||
                            ((r_state == S_DIV) && (r_cnt == DIV_LAST)));
    stall_req = (r_busy && !w_commit && !cancel) || w_accept;
  end

  // Low 2W bits of the extended-operand product equal the signed product mod 2^2W.
  assign w_signed  = ~r_op[0];
  assign w_ea      = {{DATA_W{w_signed & r_a[DATA_W-1]}}, r_a};
  assign w_eb      = {{DATA_W{w_signed & r_b[DATA_W-1]}}, r_b};
  assign w_prod    = w_ea * w_eb;
  assign w_acc     = {r_hi, r_lo};
  assign w_mul_res = !r_op[2] ? w_prod : (r_op[1] ? w_acc - w_prod : w_acc + w_prod);

  assign w_a_neg = w_signed & r_a[DATA_W-1];
  assign w_b_neg = w_signed & r_b[DATA_W-1];
  assign w_a_abs = w_a_neg ? -r_a : r_a;
  assign w_b_abs = w_b_neg ? -r_b : r_b;
  assign w_dz    = (r_b == '0);
  assign w_sh    = {r_rem, r_quo[DATA_W-1]};
  assign w_q_fix = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
  assign w_r_fix = w_a_neg ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy     <= (w_next != S_IDLE);
      r_done     <= w_commit;
      r_div_zero <= w_commit && (r_state == S_DIV) && w_dz;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (hi_we) r_hi <= hi_wdata;
          if (lo_we) r_lo <= lo_wdata;
          if (w_accept) begin
            r_op <= op;
            r_a  <= src1;
            r_b  <= src2;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_commit) {r_hi, r_lo} <= w_mul_res;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '0) begin
            r_quo <= w_a_abs;
            r_dvs <= w_b_abs;
            r_rem <= '0;
          end else if (r_cnt <= DIV_ITER) begin
            if (w_sh >= {1'b0, r_dvs}) begin
              r_rem <= DATA_W'(w_sh - {1'b0, r_dvs});
              r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
              r_rem <= w_sh[DATA_W-1:0];
              r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
          end
          if (w_commit) begin
            r_hi <= w_dz ? r_a : w_r_fix;
            r_lo <= w_dz ? '1  : w_q_fix;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (DATA_W=32, MUL_LAT=3) with hand-computed
// expected values and immediate assertions at every comparison point.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi_wdata = '0, lo_wdata = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy, done, div_zero, stall_req;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.DATA_W(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we),
    .lo_wdata(lo_wdata), .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done),
    .div_zero(div_zero), .stall_req(stall_req), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op, then wait (bounded) for done and check latency and result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dz);
    int n;
    start = 1'b1; op = o; src1 = a; src2 = b;
    #1 chk({tag, "_stall_start"}, 32'(stall_req), 32'd1);
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_hi"}, hi_o, e_hi);
    chk({tag, "_lo"}, lo_o, e_lo);
    chk({tag, "_dz"}, 32'(div_zero), 32'(e_dz));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    hi_we = 1'b1; hi_wdata = h; lo_we = 1'b1; lo_wdata = l;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int n;
    int saw_done;

    // reset state
    tick(); tick();
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    tick();

    // MULT -2 x 3 with cycle-exact stall profile
    start = 1'b1; op = 3'd0; src1 = 32'hFFFF_FFFE; src2 = 32'd3;
    #1 chk("mult_stall_c0", 32'(stall_req), 32'd1);
    tick();
    start = 1'b0;
    chk("mult_busy_c1", 32'(busy), 32'd1);
    chk("mult_stall_c1", 32'(stall_req), 32'd1);
    tick();
    chk("mult_stall_c2", 32'(stall_req), 32'd1);
    chk("mult_done_c2", 32'(done), 32'd0);
    tick();
    chk("mult_stall_c3", 32'(stall_req), 32'd0);
    chk("mult_busy_c3", 32'(busy), 32'd1);
    tick();
    chk("mult_done", 32'(done), 32'd1);
    chk("mult_busy_done", 32'(busy), 32'd0);
    chk("mult_stall_done", 32'(stall_req), 32'd0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_drop", 32'(done), 32'd0);

    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0, 34, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    tick();
    chk("divu_zero_dz_drop", 32'(div_zero), 32'd0);
    chk("divu_zero_done_drop", 32'(done), 32'd0);

    // MTHI/MTLO then accumulate
    write_hilo(32'd0, 32'hFFFF_FFFF);
    chk("mt_hi", hi_o, 32'd0);
    chk("mt_lo", lo_o, 32'hFFFF_FFFF);
    run_op("maddu", 3'd5, 32'd1, 32'd1, 3, 32'd1, 32'd0, 1'b0);
    write_hilo(32'd0, 32'd0);
    run_op("msub", 3'd6, 32'd1, 32'd1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // MTHI/MTLO in the same cycle as an accepted MADD: {5,0} + (-6)
    hi_we = 1'b1; hi_wdata = 32'd5; lo_we = 1'b1; lo_wdata = 32'd0;
    run_op("madd_samecyc", 3'd4, 32'hFFFF_FFFE, 32'd3, 3, 32'd4, 32'hFFFF_FFFA, 1'b0);

    // start and MTHI while busy are ignored
    start = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; op = 3'd0; src1 = 32'd2; src2 = 32'd2;
    hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    n = 4;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("midop_latency", 32'(n), 32'd34);
    chk("midop_hi", hi_o, 32'd2);
    chk("midop_lo", lo_o, 32'd14);
    tick();
    chk("midop_not_queued", 32'(busy), 32'd0);
    chk("midop_no_done", 32'(done), 32'd0);

    // cancel at the 5th busy cycle of a DIV
    start = 1'b1; op = 3'd2; src1 = 32'd1000; src2 = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("cancel_busy5", 32'(busy), 32'd1);
    cancel = 1'b1;
    #1 chk("cancel_stall", 32'(stall_req), 32'd0);
    tick();
    cancel = 1'b0;
    chk("cancel_busy_drop", 32'(busy), 32'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done++;
      tick();
    end
    chk("cancel_no_done", 32'(saw_done), 32'd0);
    chk("cancel_hi", hi_o, 32'd2);
    chk("cancel_lo", lo_o, 32'd14);

    // back-to-back: second start issued in the done cycle of the first
    run_op("b2b_first", 3'd0, 32'd2, 32'd3, 3, 32'd0, 32'd6, 1'b0);
    run_op("b2b_second", 3'd1, 32'd4, 32'd5, 3, 32'd0, 32'd20, 1'b0);

    // start with cancel in IDLE launches nothing
    start = 1'b1; cancel = 1'b1; op = 3'd0; src1 = 32'd9; src2 = 32'd9;
    #1 chk("idle_cancel_stall", 32'(stall_req), 32'd0);
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("idle_cancel_lo", lo_o, 32'd20);

    // asynchronous reset mid-DIV
    start = 1'b1; op = 3'd2; src1 = 32'd50; src2 = 32'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dz", 32'(div_zero), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
